// File: rtl/ad936x_pkg.sv
// ad936x_pkg: sample width and I/Q pair type shared with the ad936x data interface.
package ad936x_pkg;
  localparam int AD936X_SAMPLE_W = 12;
  typedef struct packed {
    logic [11:0] i;
    logic [11:0] q;
  } iq_sample_t;
endpackage

// File: rtl/sync_ram_1r1w.sv
// sync_ram_1r1w: one write port, registered read port; the read register is resettable, the array is not.
module sync_ram_1r1w #(
  parameter int DEPTH = 16,
  parameter int W = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // Same-address read in a write cycle returns the old word.
  always_ff @(posedge clk)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/ad936x_rx_sample_fifo.sv
// ad936x_rx_sample_fifo: never-stalling RX I/Q buffer with drop counting and a valid/ready output.
module ad936x_rx_sample_fifo
  import ad936x_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DATA_W = AD936X_SAMPLE_W,
  parameter int DROP_CNT_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in_i,
  input  logic [DATA_W-1:0]     in_q,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_i,
  output logic [DATA_W-1:0]     out_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W:0]       level,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count,
  input  logic                  clear_stats
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [2*DATA_W-1:0] rd_data;
  logic push, full, wr_en, drop, refill;
  assign push = in_valid & in_ready;
  assign full = level == (ADDR_W+1)'(DEPTH);
  assign wr_en = push & ~full;
  assign drop = push & full;
  // The RAM read register is the output stage, so a refill lands one cycle later.
  assign refill = (level != '0) & (~out_valid | out_ready);
  assign {out_i, out_q} = rd_data;
  sync_ram_1r1w #(.DEPTH(DEPTH), .W(2*DATA_W)) u_ram (
    .clk(clk), .rst_n(rst_n),
    .we(wr_en), .waddr(wr_ptr), .wdata({in_i, in_q}),
    .re(refill), .raddr(rd_ptr), .rdata(rd_data)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      in_ready <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      out_valid <= 1'b0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      in_ready <= 1'b1;
      wr_ptr <= wr_ptr + ADDR_W'(wr_en);
      rd_ptr <= rd_ptr + ADDR_W'(refill);
      level <= level + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(refill);
      out_valid <= refill | (out_valid & ~out_ready);
      overflow <= clear_stats ? drop : overflow | drop;
      drop_count <= clear_stats ? DROP_CNT_W'(drop) :
                    (drop && !(&drop_count)) ? drop_count + DROP_CNT_W'(1) : drop_count;
    end
endmodule

// File: tb/tb_ad936x_rx_sample_fifo.sv
// tb_ad936x_rx_sample_fifo: occupancy/queue reference model with a decoupled output scoreboard.
module tb_ad936x_rx_sample_fifo;
  localparam int DEPTH = 16, DW = 12, CW = 8, MAXD = (1 << CW) - 1;
  logic clk = 0, rst_n = 0;
  logic [DW-1:0] in_i = '0, in_q = '0, out_i, out_q;
  logic in_valid = 0, out_ready = 0, clear_stats = 0;
  logic in_ready, out_valid, overflow;
  logic [4:0] level;
  logic [CW-1:0] drop_count;
  ad936x_rx_sample_fifo #(.DEPTH(DEPTH), .DATA_W(DW), .DROP_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
    .in_ready(in_ready), .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow),
    .drop_count(drop_count), .clear_stats(clear_stats)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [2*DW-1:0] exp_q[$];
  int m_ram = 0, m_drop = 0, n_out = 0, n_push = 0;
  bit m_ov = 0, m_out_v = 0, m_rdy = 0, chk_en = 0;
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask
  task automatic step(bit iv, logic [DW-1:0] i, logic [DW-1:0] q, bit ordy, bit clr);
    bit push, full, refill, drop;
    in_valid = iv; in_i = i; in_q = q; out_ready = ordy; clear_stats = clr;
    @(negedge clk);
    if (chk_en) begin
      chk("level", level, m_ram);
      chk("out_valid", out_valid, m_out_v);
      chk("in_ready", in_ready, m_rdy);
      chk("overflow", overflow, m_ov);
      chk("drop_count", drop_count, m_drop);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_ram = 0; m_drop = 0; m_ov = 0; m_out_v = 0; m_rdy = 0;
      exp_q.delete();
    end else begin
      push = iv && m_rdy;
      full = m_ram == DEPTH;
      refill = m_ram > 0 && (!m_out_v || ordy);
      drop = push && full;
      if (push) n_push++;
      if (push && !full) begin
        exp_q.push_back({i, q});
        m_ram++;
      end
      if (refill) m_ram--;
      m_out_v = refill || (m_out_v && !ordy);
      m_drop = clr ? int'(drop) : (drop && m_drop < MAXD) ? m_drop + 1 : m_drop;
      m_ov = clr ? drop : (m_ov || drop);
      m_rdy = 1;
    end
    #1;
  endtask
  task automatic idle(int n, bit ordy);
    for (int k = 0; k < n; k++) step(0, '0, '0, ordy, 0);
  endtask
  logic [2*DW-1:0] prev;
  bit stall = 0;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (stall && out_valid) chk("stall_stable", {out_i, out_q}, prev);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected got %0h want none", {out_i, out_q});
        end else chk("out_data", {out_i, out_q}, exp_q.pop_front());
        n_out++;
      end
      stall = out_valid && !out_ready;
      prev = {out_i, out_q};
    end else stall = 0;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int base, pbase;
    rst_n = 0;
    step(1, 12'h111, 12'h222, 1, 0);
    chk_en = 1;
    step(1, 12'h111, 12'h222, 1, 0);
    step(1, 12'h111, 12'h222, 1, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_drop_count", drop_count, 0);
    rst_n = 1;
    idle(2, 1);
    chk("in_ready_after_rst", in_ready, 1);
    step(1, 12'h123, 12'hABC, 1, 0);
    chk("single_t1_valid", out_valid, 0);
    idle(1, 1);
    chk("single_t2_valid", out_valid, 1);
    chk("single_i", out_i, 12'h123);
    chk("single_q", out_q, 12'hABC);
    idle(1, 1);
    chk("single_t3_valid", out_valid, 0);
    base = n_out;
    for (int n = 0; n < 100; n++) begin
      step(1, DW'(n), ~DW'(n), 1, 0);
      chk("stream_level_le2", level <= 2, 1);
    end
    idle(3, 1);
    chk("stream_count", n_out - base, 100);
    chk("stream_drops", drop_count, 0);
    base = n_out;
    for (int k = 0; k < DEPTH + 6; k++) step(1, DW'(k), DW'(k) | 12'h800, 0, 0);
    chk("ovf_level", level, DEPTH);
    chk("ovf_drops", drop_count, 5);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head_i", out_i, 0);
    chk("ovf_head_q", out_q, 12'h800);
    idle(20, 1);
    chk("ovf_drain_count", n_out - base, DEPTH + 1);
    step(0, '0, '0, 0, 1);
    chk("clr_drop", drop_count, 0);
    for (int k = 0; k < DEPTH + 4; k++) step(1, DW'(k + 40), DW'(k + 80), 0, 0);
    chk("pre_clr_drop", drop_count, 3);
    step(1, 12'hFFF, 12'hFFF, 0, 1);
    chk("clr_with_drop_cnt", drop_count, 1);
    chk("clr_with_drop_ovf", overflow, 1);
    step(0, '0, '0, 0, 1);
    chk("clean_clr_cnt", drop_count, 0);
    chk("clean_clr_ovf", overflow, 0);
    for (int k = 0; k < MAXD + 45; k++) step(1, DW'(k), DW'(k), 0, 0);
    chk("sat_cnt", drop_count, MAXD);
    idle(20, 1);
    chk("sat_drain_empty", exp_q.size(), 0);
    for (int c = 0; c < 5000; c++) begin
      if (c == 2500) rst_n = 0;
      if (c == 2502) rst_n = 1;
      step($urandom_range(0, 3) != 0, DW'($urandom), DW'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    end
    idle(20, 1);
    step(0, '0, '0, 1, 1);
    base = n_out;
    pbase = n_push;
    for (int c = 0; c < 5000; c++)
      step($urandom_range(0, 1) == 1, DW'($urandom), DW'($urandom),
           $urandom_range(0, 9) < 7, 0);
    idle(25, 1);
    chk("rand_drain_empty", exp_q.size(), 0);
    chk("rand_level_zero", level, 0);
    if (drop_count < MAXD)
      chk("rand_accounting", (n_out - base) + drop_count, n_push - pbase);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
